// File: rtl/boundary_link_arbiter_pkg.sv
// Shared definitions for the boundary link arbiter: arbitration modes and link width helpers.
package link_pkg;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  function automatic int unsigned tag_width(int unsigned channel_count);
    return (channel_count == 0) ? 1 : $clog2(channel_count + 1);
  endfunction

  function automatic int unsigned link_width(int unsigned channel_count,
                                             int unsigned payload_width);
    return payload_width + tag_width(channel_count);
  endfunction

endpackage

// File: rtl/boundary_link_arbiter_if.sv
// Channel and link handshake bundle; master is the arbiter side, slave the surrounding fabric.
interface boundary_link_arbiter_if import link_pkg::*; #(
  parameter int unsigned CHANNEL_COUNT = 20,
  parameter int unsigned PAYLOAD_WIDTH = 20
);
  localparam int unsigned NumCh = CHANNEL_COUNT + 1;
  localparam int unsigned LinkW = link_width(CHANNEL_COUNT, PAYLOAD_WIDTH);

  logic [PAYLOAD_WIDTH*NumCh-1:0] ch_out_data;
  logic [NumCh-1:0]               ch_out_valid;
  logic [NumCh-1:0]               ch_out_ready;
  logic [PAYLOAD_WIDTH*NumCh-1:0] ch_in_data;
  logic [NumCh-1:0]               ch_in_valid;
  logic [NumCh-1:0]               ch_in_ready;
  logic [LinkW-1:0]               link_out_data;
  logic                           link_out_valid;
  logic                           link_out_ready;
  logic [LinkW-1:0]               link_in_data;
  logic                           link_in_valid;
  logic                           link_in_ready;
  logic                           has_flying_messages;
  logic                           tag_error;

  modport master (
    input  ch_out_data, ch_out_valid, ch_in_ready, link_out_ready, link_in_data, link_in_valid,
    output ch_out_ready, ch_in_data, ch_in_valid, link_out_data, link_out_valid, link_in_ready,
    output has_flying_messages, tag_error
  );

  modport slave (
    output ch_out_data, ch_out_valid, ch_in_ready, link_out_ready, link_in_data, link_in_valid,
    input  ch_out_ready, ch_in_data, ch_in_valid, link_out_data, link_out_valid, link_in_ready,
    input  has_flying_messages, tag_error
  );

endinterface

// File: rtl/boundary_link_arbiter_rr_arbiter.sv
// Single-grant arbiter: round-robin from last grant, or fixed priority (top index, then lowest).
module rr_arbiter import link_pkg::*; #(
  parameter int unsigned NumReq = 21,
  parameter int unsigned IdxW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NumReq-1:0] req_i,
  input  logic              en_i,
  input  logic              mode_i,   // 1: fixed priority
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  logic [IdxW-1:0] last_q, last_d;
  logic [IdxW-1:0] idx;
  logic [IdxW:0]   sum;
  logic            found;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    if (mode_i) begin
      if (req_i[NumReq-1]) begin
        found = 1'b1;
        idx   = IdxW'(NumReq - 1);
      end else begin
        for (int unsigned i = 0; i < NumReq - 1; i++) begin
          if (!found && req_i[i]) begin
            found = 1'b1;
            idx   = IdxW'(i);
          end
        end
      end
    end else begin
      // Candidate index last+k wraps once at most since last < NumReq and k <= NumReq.
      for (int unsigned k = 1; k <= NumReq; k++) begin
        sum = {1'b0, last_q} + (IdxW+1)'(k);
        if (sum >= (IdxW+1)'(NumReq)) sum = sum - (IdxW+1)'(NumReq);
        if (!found && req_i[sum[IdxW-1:0]]) begin
          found = 1'b1;
          idx   = sum[IdxW-1:0];
        end
      end
    end
  end

  always_comb begin
    valid_o = found && en_i;
    idx_o   = idx;
    gnt_o   = '0;
    if (valid_o) gnt_o[idx] = 1'b1;
    last_d = valid_o ? idx : last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= IdxW'(NumReq - 1);
    else       last_q <= last_d;
  end

endmodule

// File: rtl/boundary_link_arbiter.sv
// Merges PU and stage-controller channels onto a tagged link through an output queue,
// demultiplexes inbound link words, and reports in-flight traffic for termination detection.
module boundary_link_arbiter import link_pkg::*; #(
  parameter int unsigned CHANNEL_COUNT = 20,
  parameter int unsigned PAYLOAD_WIDTH = 20,
  parameter int unsigned OUT_DEPTH     = 4,
  parameter int unsigned ARB_MODE      = ARB_RR,
  parameter int unsigned LINGER_CYCLES = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  boundary_link_arbiter_if.master       link_io
);

  localparam int unsigned NumCh = CHANNEL_COUNT + 1;
  localparam int unsigned TagW  = tag_width(CHANNEL_COUNT);
  localparam int unsigned AddrW = $clog2(OUT_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam int unsigned LingW = $clog2(LINGER_CYCLES + 2);

  typedef struct packed {
    logic [TagW-1:0]          tag;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } link_word_t;

  // Outbound arbitration and queue
  logic [NumCh-1:0] gnt;
  logic [TagW-1:0]  gnt_idx;
  logic             push, pop, full, empty;
  link_word_t       push_word;

  link_word_t       mem_q [OUT_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  rr_arbiter #(
    .NumReq (NumCh),
    .IdxW   (TagW)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_i   (link_io.ch_out_valid),
    .en_i    (!full),
    .mode_i  (ARB_MODE == ARB_FIXED),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (push)
  );

  always_comb begin
    full              = (cnt_q == CntW'(OUT_DEPTH));
    empty             = (cnt_q == '0);
    pop               = !empty && link_io.link_out_ready;
    push_word.tag     = gnt_idx;
    push_word.payload = link_io.ch_out_data[gnt_idx*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    wr_ptr_d          = push ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
    rd_ptr_d          = pop  ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
    cnt_d             = cnt_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  assign link_io.ch_out_ready   = gnt;
  assign link_io.link_out_valid = !empty;
  assign link_io.link_out_data  = mem_q[rd_ptr_q];

  // Inbound holding register
  link_word_t       hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic             tag_error_q, tag_error_d;
  logic             hold_legal, hold_done, in_ready;
  logic [NumCh-1:0] in_valid;

  always_comb begin
    hold_legal   = (hold_q.tag <= TagW'(CHANNEL_COUNT));
    // An illegal word has no consumer and drains unconditionally.
    hold_done    = hold_valid_q && (!hold_legal || link_io.ch_in_ready[hold_q.tag]);
    in_ready     = !hold_valid_q || hold_done;
    in_valid     = '0;
    if (hold_valid_q && hold_legal) in_valid[hold_q.tag] = 1'b1;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (link_io.link_in_valid && in_ready) begin
      hold_d       = link_io.link_in_data;
      hold_valid_d = 1'b1;
    end else if (hold_done) begin
      hold_valid_d = 1'b0;
    end
    tag_error_d = tag_error_q || (hold_valid_q && !hold_legal);
  end

  assign link_io.link_in_ready = in_ready;
  assign link_io.ch_in_valid   = in_valid;
  assign link_io.ch_in_data    = {NumCh{hold_q.payload}};
  assign link_io.tag_error     = tag_error_q;

  // Quiescence linger
  logic             activity;
  logic [LingW-1:0] linger_q, linger_d;

  always_comb begin
    activity = !empty || hold_valid_q || (|link_io.ch_out_valid);
    if (activity)            linger_d = LingW'(LINGER_CYCLES);
    else if (linger_q != '0) linger_d = linger_q - LingW'(1);
    else                     linger_d = '0;
  end

  assign link_io.has_flying_messages = activity || (linger_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      tag_error_q  <= 1'b0;
      linger_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      tag_error_q  <= tag_error_d;
      linger_q     <= linger_d;
    end
  end

endmodule

// File: tb/tb_boundary_link_arbiter.sv
// Two arbiters (3-channel round-robin, 5-channel fixed priority) checked every cycle against a
// queue-based reference model, plus directed scenarios with hand-computed expectations.
module tb_boundary_link_arbiter;

  localparam int unsigned P     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LING  = 3;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  boundary_link_arbiter_if #(.CHANNEL_COUNT(3), .PAYLOAD_WIDTH(P)) bus_a ();
  boundary_link_arbiter_if #(.CHANNEL_COUNT(5), .PAYLOAD_WIDTH(P)) bus_b ();

  boundary_link_arbiter #(
    .CHANNEL_COUNT (3),
    .PAYLOAD_WIDTH (P),
    .OUT_DEPTH     (DEPTH),
    .ARB_MODE      (0),
    .LINGER_CYCLES (LING)
  ) dut_a (
    .clk     (clk),
    .reset   (rst_a),
    .link_io (bus_a)
  );

  boundary_link_arbiter #(
    .CHANNEL_COUNT (5),
    .PAYLOAD_WIDTH (P),
    .OUT_DEPTH     (DEPTH),
    .ARB_MODE      (1),
    .LINGER_CYCLES (LING)
  ) dut_b (
    .clk     (clk),
    .reset   (rst_b),
    .link_io (bus_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [63:0] cod;
    logic [7:0]  cov, cor, civ, cir;
    logic [63:0] cid;
    logic [15:0] lod, lid;
    logic        lov, lor, liv, lir, fly, terr, rst;
  } snap_t;

  function automatic snap_t snap_a();
    snap_t s;
    s.cod = 64'(bus_a.ch_out_data);   s.cov = 8'(bus_a.ch_out_valid);
    s.cor = 8'(bus_a.ch_out_ready);   s.cid = 64'(bus_a.ch_in_data);
    s.civ = 8'(bus_a.ch_in_valid);    s.cir = 8'(bus_a.ch_in_ready);
    s.lod = 16'(bus_a.link_out_data); s.lov = bus_a.link_out_valid;
    s.lor = bus_a.link_out_ready;     s.lid = 16'(bus_a.link_in_data);
    s.liv = bus_a.link_in_valid;      s.lir = bus_a.link_in_ready;
    s.fly = bus_a.has_flying_messages; s.terr = bus_a.tag_error; s.rst = rst_a;
    return s;
  endfunction

  function automatic snap_t snap_b();
    snap_t s;
    s.cod = 64'(bus_b.ch_out_data);   s.cov = 8'(bus_b.ch_out_valid);
    s.cor = 8'(bus_b.ch_out_ready);   s.cid = 64'(bus_b.ch_in_data);
    s.civ = 8'(bus_b.ch_in_valid);    s.cir = 8'(bus_b.ch_in_ready);
    s.lod = 16'(bus_b.link_out_data); s.lov = bus_b.link_out_valid;
    s.lor = bus_b.link_out_ready;     s.lid = 16'(bus_b.link_in_data);
    s.liv = bus_b.link_in_valid;      s.lir = bus_b.link_in_ready;
    s.fly = bus_b.has_flying_messages; s.terr = bus_b.tag_error; s.rst = rst_b;
    return s;
  endfunction

  // Reference model state, one slot per DUT; link words held as (tag << 8) | payload
  int          cc_of[2]   = '{3, 5};
  int          mode_of[2] = '{0, 1};
  logic [15:0] mq[2][$];
  int          last_g[2];
  bit          hv[2];
  logic [15:0] hword[2];
  bit          terr[2];
  int          ling[2];
  bit          on[2];

  // Observations for the directed scenarios
  int otags[2][$];
  int deliv0[$];
  int acc0, lir_low0;
  bit civ_seen1;

  function automatic void step(int d, snap_t s);
    string       pf = (d == 0) ? "A" : "B";
    int          cc = cc_of[d];
    int          n = cc + 1;
    int          g = -1;
    int          htag;
    bit          legal, done, act, exp_lir;
    logic [7:0]  exp_cor = '0;
    logic [7:0]  exp_civ = '0;
    logic [63:0] exp_cid = '0;
    if (!on[d]) begin
      if (s.rst === 1'b1) begin
        mq[d].delete(); last_g[d] = cc; hv[d] = 0; terr[d] = 0; ling[d] = 0; on[d] = 1;
      end
      return;
    end
    if (mq[d].size() < DEPTH) begin
      if (mode_of[d] == 1) begin
        if (s.cov[cc]) g = cc;
        else for (int i = 0; i < cc; i++) if (g < 0 && s.cov[i]) g = i;
      end else begin
        for (int k = 1; k <= n; k++) if (g < 0 && s.cov[(last_g[d] + k) % n]) g = (last_g[d] + k) % n;
      end
    end
    if (g >= 0) exp_cor[g] = 1'b1;
    chk({pf, " ch_out_ready"}, 64'(s.cor), 64'(exp_cor));
    chk({pf, " link_out_valid"}, 64'(s.lov), 64'(mq[d].size() != 0));
    if (mq[d].size() != 0) chk({pf, " link_out_data"}, 64'(s.lod), 64'(mq[d][0]));
    htag  = int'(hword[d] >> 8);
    legal = htag <= cc;
    if (hv[d] && legal) exp_civ[htag] = 1'b1;
    for (int i = 0; i < n; i++) exp_cid[i*8 +: 8] = hword[d][7:0];
    chk({pf, " ch_in_valid"}, 64'(s.civ), 64'(exp_civ));
    if (exp_civ != 0) chk({pf, " ch_in_data"}, s.cid, exp_cid);
    done    = hv[d] && (!legal || s.cir[htag]);
    exp_lir = !hv[d] || done;
    chk({pf, " link_in_ready"}, 64'(s.lir), 64'(exp_lir));
    act = (mq[d].size() != 0) || hv[d] || (s.cov != 0);
    chk({pf, " has_flying_messages"}, 64'(s.fly), 64'(act || ling[d] != 0));
    chk({pf, " tag_error"}, 64'(s.terr), 64'(terr[d]));

    if (s.lov === 1'b1 && s.lor) otags[d].push_back(int'(s.lod >> 8));
    if (d == 0) begin
      if ((s.cor & s.cov) != 0) acc0++;
      for (int i = 0; i < 4; i++) if (s.civ[i] === 1'b1 && s.cir[i]) deliv0.push_back(i);
      if (s.lir !== 1'b1) lir_low0++;
    end else if (s.civ != 0) begin
      civ_seen1 = 1;
    end

    if (s.rst) begin
      mq[d].delete(); last_g[d] = cc; hv[d] = 0; terr[d] = 0; ling[d] = 0;
    end else begin
      if (hv[d] && !legal) terr[d] = 1;
      if (mq[d].size() != 0 && s.lor) void'(mq[d].pop_front());
      if (g >= 0) begin
        mq[d].push_back(16'((g << 8) | int'(s.cod[g*8 +: 8])));
        last_g[d] = g;
      end
      if (s.liv && exp_lir) begin
        hv[d] = 1; hword[d] = s.lid;
      end else if (done) begin
        hv[d] = 0;
      end
      ling[d] = act ? LING : (ling[d] > 0 ? ling[d] - 1 : 0);
    end
  endfunction

  always @(negedge clk) begin
    step(0, snap_a());
    step(1, snap_b());
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus_a.ch_out_data = '0; bus_a.ch_out_valid = '0; bus_a.ch_in_ready = '1;
    bus_a.link_out_ready = 1'b0; bus_a.link_in_valid = 1'b0; bus_a.link_in_data = '0;
    bus_b.ch_out_data = '0; bus_b.ch_out_valid = '0; bus_b.ch_in_ready = '1;
    bus_b.link_out_ready = 1'b0; bus_b.link_in_valid = 1'b0; bus_b.link_in_data = '0;
  endtask

  task automatic pulse_rst_a();
    rst_a = 1'b1; cyc(1); rst_a = 1'b0;
  endtask

  int exp_fp[8] = '{5, 5, 5, 5, 1, 1, 1, 1};
  int t;

  initial begin
    idle_all();
    rst_a = 1'b1; rst_b = 1'b1;
    cyc(2);
    rst_a = 1'b0; rst_b = 1'b0;

    @(negedge clk);
    chk("reset link_out_valid", 64'(bus_a.link_out_valid), 64'd0);
    chk("reset link_in_ready", 64'(bus_a.link_in_ready), 64'd1);
    chk("reset ch_in_valid", 64'(bus_a.ch_in_valid), 64'd0);
    chk("reset ch_out_ready", 64'(bus_a.ch_out_ready), 64'd0);
    chk("reset has_flying", 64'(bus_a.has_flying_messages), 64'd0);
    chk("reset tag_error", 64'(bus_b.tag_error), 64'd0);
    @(posedge clk); #1;

    // Round-robin with every channel requesting
    otags[0].delete();
    bus_a.ch_out_data = 32'hD3C2B1A0; bus_a.ch_out_valid = 4'hF; bus_a.link_out_ready = 1'b1;
    cyc(8);
    bus_a.ch_out_valid = '0;
    cyc(3);
    chk("rr word count", 64'(otags[0].size()), 64'd8);
    if (otags[0].size() == 8)
      for (int i = 0; i < 8; i++) chk("rr tag order", 64'(otags[0][i]), 64'(i % 4));

    // Queue full with link stalled
    pulse_rst_a();
    acc0 = 0;
    bus_a.ch_out_valid = 4'b0001; bus_a.link_out_ready = 1'b0;
    cyc(8);
    chk("full accepts", 64'(acc0), 64'd4);
    chk("full ready low", 64'(bus_a.ch_out_ready), 64'd0);
    acc0 = 0;
    bus_a.link_out_ready = 1'b1; cyc(1);
    bus_a.link_out_ready = 1'b0; cyc(5);
    chk("accepts after one pop", 64'(acc0), 64'd1);
    bus_a.ch_out_valid = '0; bus_a.link_out_ready = 1'b1; cyc(6);
    bus_a.link_out_ready = 1'b0;

    // Inbound routing with channel 2 stalled
    deliv0.delete(); lir_low0 = 0;
    bus_a.ch_in_ready = 4'b1011;
    bus_a.link_in_valid = 1'b1; bus_a.link_in_data = {2'd2, 8'hA2}; cyc(1);
    bus_a.link_in_data = {2'd0, 8'hB0}; cyc(3);
    bus_a.ch_in_ready = 4'hF; cyc(1);
    bus_a.link_in_valid = 1'b0; cyc(3);
    chk("inbound stall cycles", 64'(lir_low0), 64'd3);
    chk("inbound delivery count", 64'(deliv0.size()), 64'd2);
    if (deliv0.size() == 2) begin
      chk("inbound first target", 64'(deliv0[0]), 64'd2);
      chk("inbound second target", 64'(deliv0[1]), 64'd0);
    end

    // Linger after a single word
    pulse_rst_a();
    bus_a.ch_out_valid = 4'b0010; bus_a.link_out_ready = 1'b1; cyc(1);
    bus_a.ch_out_valid = '0;
    @(negedge clk);
    chk("linger word queued", 64'(bus_a.link_out_valid), 64'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("linger still flying", 64'(bus_a.has_flying_messages), 64'd1);
    end
    @(negedge clk);
    chk("linger expired", 64'(bus_a.has_flying_messages), 64'd0);
    @(posedge clk); #1;

    // Reset with two queued words
    bus_a.link_out_ready = 1'b0; bus_a.ch_out_valid = 4'b0001; cyc(2);
    bus_a.ch_out_valid = '0;
    chk("two words queued", 64'(bus_a.link_out_valid), 64'd1);
    pulse_rst_a();
    @(negedge clk);
    chk("queue cleared by reset", 64'(bus_a.link_out_valid), 64'd0);
    @(posedge clk); #1;

    // Fixed priority: stage controller (5) beats channel 1
    otags[1].delete();
    bus_b.ch_out_data = 48'hF5E4D3C2B1A0; bus_b.link_out_ready = 1'b1;
    bus_b.ch_out_valid = 6'b100010; cyc(4);
    bus_b.ch_out_valid = 6'b000010; cyc(4);
    bus_b.ch_out_valid = '0; cyc(3);
    chk("fixed word count", 64'(otags[1].size()), 64'd8);
    if (otags[1].size() == 8)
      for (int i = 0; i < 8; i++) chk("fixed tag order", 64'(otags[1][i]), 64'(exp_fp[i]));

    // Illegal inbound tag
    civ_seen1 = 0;
    bus_b.link_in_valid = 1'b1; bus_b.link_in_data = {3'd7, 8'h5A}; cyc(1);
    bus_b.link_in_valid = 1'b0; cyc(3);
    chk("illegal tag no delivery", 64'(civ_seen1), 64'd0);
    chk("illegal tag flagged", 64'(bus_b.tag_error), 64'd1);
    cyc(10);
    chk("tag_error sticky", 64'(bus_b.tag_error), 64'd1);
    rst_b = 1'b1; cyc(1); rst_b = 1'b0;
    chk("tag_error cleared", 64'(bus_b.tag_error), 64'd0);

    // Randomized traffic in both directions with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst_a = ($urandom % 300) == 0;
      rst_b = ($urandom % 300) == 0;
      bus_a.ch_out_valid   = 4'($urandom & $urandom);
      bus_a.ch_out_data    = $urandom;
      bus_a.ch_in_ready    = 4'($urandom | $urandom);
      bus_a.link_out_ready = ($urandom % 4) != 0;
      bus_a.link_in_valid  = $urandom % 2;
      bus_a.link_in_data   = 10'($urandom);
      bus_b.ch_out_valid   = 6'($urandom & $urandom);
      bus_b.ch_out_data    = 48'({$urandom, $urandom});
      bus_b.ch_in_ready    = 6'($urandom | $urandom);
      bus_b.link_out_ready = ($urandom % 4) != 0;
      bus_b.link_in_valid  = $urandom % 2;
      t = (($urandom % 20) == 0) ? 6 + ($urandom % 2) : ($urandom % 6);
      bus_b.link_in_data   = {3'(t), 8'($urandom)};
      cyc(1);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    idle_all();
    cyc(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
